ddr2_cmd_arbiter: RTL
=====================

# ddr2_cmd_arbiter

Shares the single MCB port-0 command interface between a write client and a read client. Each client presents a command request (address, burst length); the arbiter gates on calibration and command-FIFO space, grants alternately when both request, and drives `p0_cmd_*`. It also tracks read words issued but not yet popped, and withholds read commands that would overflow the MCB read-data FIFO.

## Interface
- `ADDR_W`, 30: byte-address width of `p0_cmd_byte_addr`.
- `BL_W`, 6: burst-length field width; the value encodes words-1.
- `RD_FIFO_DEPTH`, 64: MCB read-data FIFO depth in 32-bit words; range 2..64.
- `CNT_W`, 7: width of the outstanding-read counter; must satisfy `2^CNT_W > RD_FIFO_DEPTH`.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `calib_done` in 1: MCB calibration complete.
- `wr_req` in 1: write client requests a command; held until `wr_gnt`.
- `wr_addr` in ADDR_W: write byte address; stable while `wr_req`.
- `wr_bl` in BL_W: write burst length-1; stable while `wr_req`.
- `wr_gnt` out 1: one-cycle pulse; write command issued.
- `rd_req`, `rd_addr`, `rd_bl`, `rd_gnt`: read-client equivalents of the write-client ports.
- `p0_cmd_full` in 1: MCB command FIFO full.
- `p0_cmd_en` out 1: command strobe.
- `p0_cmd_instr` out 3: 3'b000 for write, 3'b001 for read.
- `p0_cmd_byte_addr` out ADDR_W: command address.
- `p0_cmd_bl` out BL_W: command burst length-1.
- `p0_rd_en` in 1: read-data FIFO pop, driven by the read consumer; each high cycle pops one word.
- `rd_outstanding` out CNT_W: read words issued and not yet popped.
- `rd_underflow` out 1: sticky; set when `p0_rd_en` is high while `rd_outstanding` is 0.

## Operation
- States: S_IDLE, S_ISSUE, S_GAP.
- **S_IDLE:**
  - `wr_ok = wr_req`.
  - `rd_ok = rd_req && (rd_outstanding + rd_bl + 1 <= RD_FIFO_DEPTH)`. The sum is evaluated at CNT_W+1 bits, with no wrap.
  - If `calib_done && !p0_cmd_full && (wr_ok || rd_ok)`, select a winner:
    - If only one client is eligible, it wins.
    - If both are eligible, the client not named by `last_gnt` wins.
  - Load `p0_cmd_instr`, `p0_cmd_byte_addr` and `p0_cmd_bl` from the winner, record the winner in `last_gnt`, and go to S_ISSUE.
  - Otherwise stay in S_IDLE.
- **S_ISSUE:** `p0_cmd_en` = 1 and the winner's `*_gnt` = 1 for exactly this cycle. Next state is S_GAP. The command is not re-qualified against `p0_cmd_full` or `calib_done`.
- **S_GAP:** `p0_cmd_en` = 0, and no request is sampled. This absorbs the client's request deassertion and the `p0_cmd_full` update latency. Next state is S_IDLE.
- `last_gnt` resets to "read", so the first contended grant goes to write.
- **Outstanding counter,** updated every cycle:
  - Add `bl+1` in the S_ISSUE cycle of a read command.
  - Subtract 1 on `p0_rd_en`.
  - When both happen in the same cycle, apply the net change (`+bl`).
  - `p0_rd_en` with the counter at 0 leaves it at 0 and sets `rd_underflow`.
- `p0_cmd_instr`, `p0_cmd_byte_addr` and `p0_cmd_bl` hold their values after issue until the next load.
- Reset while `reset_n` = 0 takes priority over all other actions, including S_ISSUE mid-command. The block goes to S_IDLE; all outputs, `rd_outstanding`, `rd_underflow` and `last_gnt` return to reset values.

## Timing
- Reset values:
  - `p0_cmd_en`, `wr_gnt`, `rd_gnt`, `rd_underflow`: 0.
  - `p0_cmd_instr`: 3'b000.
  - `p0_cmd_byte_addr`, `p0_cmd_bl`, `rd_outstanding`: 0.
  - State: S_IDLE.
- A request sampled in S_IDLE at cycle N produces `p0_cmd_en` and `*_gnt` at N+1. The command fields are valid from N+1.
- Maximum throughput is one command every 3 cycles.
- Clients deassert `*_req` at N+2 or present the next command. The arbiter does not sample requests before N+3.
- `rd_outstanding` reflects an issued read starting the cycle after S_ISSUE.
- A read blocked by credit does not block an eligible write in the same S_IDLE cycle.

## Test plan
- **Calibration gate:** hold `calib_done` = 0 with `wr_req` = 1 for 20 cycles, then raise it. Required: no `p0_cmd_en` while low; `p0_cmd_en` and `wr_gnt` one cycle after the rise, with instr 000 and the `wr_addr`/`wr_bl` values.
- **Alternating grants:** hold `wr_req` and `rd_req` together (`bl` = 9, `p0_rd_en` draining). Required: grant order W, R, W, R; `p0_cmd_en` strobes exactly 3 cycles apart.
- **Read credit:** `RD_FIFO_DEPTH` = 64, `rd_bl` = 31, no pops. Required: two reads issue and `rd_outstanding` = 64. A third read stays blocked. Pop 32 words, then the third read issues.
- **Command-FIFO full:** hold `p0_cmd_full` = 1 for 10 cycles with both requests pending. Required: no strobe. After release, a strobe follows on the next S_IDLE sample.
- **Simultaneous and underflow:**
  - Read issue (`bl` = 9) in the same cycle as `p0_rd_en` with `rd_outstanding` = 5. Required: 14.
  - `p0_rd_en` at 0. Required: counter stays at 0 and `rd_underflow` = 1 until reset.
- **Reset mid-command:** assert `reset_n` = 0 in the S_ISSUE cycle. Required: the next cycle shows all outputs at reset values. The next contended grant goes to write.

Source files
------------

// File: rtl/ddr2_cmd_arbiter.sv
// ddr2_cmd_arbiter: shares the MCB port-0 command interface between a write
// client and a read client. Grants alternate under contention, commands are
// gated on calibration, command-FIFO space and read-data FIFO credit.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | sample requests, pick a winner, load command fields
// S_ISSUE | p0_cmd_en and the winner's grant are high for this one cycle
// S_GAP   | no sampling; covers request drop and p0_cmd_full latency
module ddr2_cmd_arbiter #(
    parameter int ADDR_W        = 30,
    parameter int BL_W          = 6,
    parameter int RD_FIFO_DEPTH = 64,
    parameter int CNT_W         = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              calib_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BL_W-1:0]   wr_bl,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BL_W-1:0]   rd_bl,
    output logic              rd_gnt,
    input  logic              p0_cmd_full,
    output logic              p0_cmd_en,
    output logic [2:0]        p0_cmd_instr,
    output logic [ADDR_W-1:0] p0_cmd_byte_addr,
    output logic [BL_W-1:0]   p0_cmd_bl,
    input  logic              p0_rd_en,
    output logic [CNT_W-1:0]  rd_outstanding,
    output logic              rd_underflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Credit sum is one bit wider than the counter so it cannot wrap.
    localparam int SUM_W = CNT_W + 1;

    logic [1:0]        state_q, state_d;
    logic              last_wr_q, last_wr_d;   // 1: last grant went to write
    logic [2:0]        instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BL_W-1:0]   bl_q, bl_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              unf_q, unf_d;

    logic [SUM_W-1:0]  rd_sum;
    logic              wr_ok, rd_ok, sel_wr, issue_rd, pop_ok;
    logic [CNT_W-1:0]  add_amt;

    // Eligibility: reads need room for their whole burst in the read-data FIFO.
    always_comb begin
        rd_sum = SUM_W'(cnt_q) + SUM_W'(rd_bl) + SUM_W'(1);
        wr_ok  = wr_req;
        rd_ok  = rd_req && (rd_sum <= SUM_W'(RD_FIFO_DEPTH));
        sel_wr = wr_ok && (!rd_ok || !last_wr_q);
    end

    // Arbitration FSM and command field load.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        instr_d   = instr_q;
        addr_d    = addr_q;
        bl_d      = bl_q;
        case (state_q)
            S_IDLE: begin
                if (calib_done && !p0_cmd_full && (wr_ok || rd_ok)) begin
                    last_wr_d = sel_wr;
                    instr_d   = sel_wr ? 3'b000 : 3'b001;
                    addr_d    = sel_wr ? wr_addr : rd_addr;
                    bl_d      = sel_wr ? wr_bl : rd_bl;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outstanding read words: add the burst on read issue, remove one per pop.
    // A pop against an empty count is ignored and flagged as underflow.
    always_comb begin
        issue_rd = (state_q == S_ISSUE) && !last_wr_q;
        pop_ok   = p0_rd_en && (cnt_q != '0);
        add_amt  = issue_rd ? (CNT_W'(bl_q) + CNT_W'(1)) : '0;
        cnt_d    = cnt_q + add_amt - CNT_W'(pop_ok);
        unf_d    = unf_q | (p0_rd_en && (cnt_q == '0));
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            instr_q   <= 3'b000;
            addr_q    <= '0;
            bl_q      <= '0;
            cnt_q     <= '0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            instr_q   <= instr_d;
            addr_q    <= addr_d;
            bl_q      <= bl_d;
            cnt_q     <= cnt_d;
            unf_q     <= unf_d;
        end
    end

    // Strobes decode directly from state so a reset clears them the next cycle.
    always_comb begin
        p0_cmd_en        = (state_q == S_ISSUE);
        wr_gnt           = p0_cmd_en && last_wr_q;
        rd_gnt           = p0_cmd_en && !last_wr_q;
        p0_cmd_instr     = instr_q;
        p0_cmd_byte_addr = addr_q;
        p0_cmd_bl        = bl_q;
        rd_outstanding   = cnt_q;
        rd_underflow     = unf_q;
    end

endmodule
